// File: rtl/sprite_pkg.sv
// Shared types and defaults for the sprite ROM arbiter.
// Read tags travel down the ROM latency pipe.
package sprite_pkg;

    localparam int SPR_AW      = 10;
    localparam int SPR_DW      = 4;
    localparam int SPR_ROM_LAT = 1;
    localparam int SPR_NREQ    = 4;

    // id field sized for the largest supported requester count (8)
    localparam int SPR_NREQ_MAX = 8;
    localparam int SPR_IDW      = $clog2(SPR_NREQ_MAX);

    typedef logic [SPR_IDW-1:0] req_id_t;

    typedef struct packed {
        logic    v;
        req_id_t id;
    } rd_tag_t;

endpackage

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Rotated priority encoder: first request at or after ptr wins.
// Purely combinational.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] id,
    output logic          any
);

    int            j;
    logic [IW-1:0] jj;

    always_comb begin
        gnt = '0;
        id  = '0;
        any = 1'b0;
        j   = 0;
        jj  = '0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            jj = IW'(j);
            if (!any && req[jj]) begin
                any     = 1'b1;
                gnt[jj] = 1'b1;
                id      = jj;
            end
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin sharing of one synchronous sprite ROM between renderers;
// each returned word is tagged back to the requester that was granted.
module sprite_rom_arbiter
    import sprite_pkg::*;
#(
    parameter int NREQ    = SPR_NREQ,
    parameter int AW      = SPR_AW,
    parameter int DW      = SPR_DW,
    parameter int ROM_LAT = SPR_ROM_LAT
) (
    input  logic                 vga_clk,
    input  logic                 reset,
    input  logic                 frame_start,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   addr,
    output logic [NREQ-1:0]      gnt,
    output logic [AW-1:0]        rom_address,
    input  logic [DW-1:0]        rom_q,
    output logic [DW-1:0]        rdata,
    output logic [NREQ-1:0]      rvalid,
    output logic                 busy
);

    localparam int IW = $clog2(NREQ);

    logic [IW-1:0]   ptr;
    logic [IW-1:0]   ptr_nxt;
    logic [IW-1:0]   win;
    logic [NREQ-1:0] pick_gnt;
    logic            any;
    logic            pipe_any;
    rd_tag_t         pipe [ROM_LAT];
    rd_tag_t         tail;

    rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_pick (
        .req (req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .id  (win),
        .any (any)
    );

    // frame_start takes precedence over the post-grant advance
    always_comb begin
        ptr_nxt = ptr;
        if (any) begin
            if (win == IW'(NREQ - 1)) begin
                ptr_nxt = '0;
            end else begin
                ptr_nxt = win + IW'(1);
            end
        end
        if (frame_start) begin
            ptr_nxt = '0;
        end
    end

    always_comb begin
        gnt         = '0;
        rom_address = '0;
        if (!reset) begin
            gnt = pick_gnt;
            for (int i = 0; i < NREQ; i++) begin
                if (pick_gnt[i]) begin
                    rom_address = addr[i*AW +: AW];
                end
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            ptr <= '0;
            for (int k = 0; k < ROM_LAT; k++) begin
                pipe[k] <= '0;
            end
        end else begin
            ptr       <= ptr_nxt;
            pipe[0].v  <= any;
            pipe[0].id <= req_id_t'(win);
            for (int k = 1; k < ROM_LAT; k++) begin
                pipe[k] <= pipe[k-1];
            end
        end
    end

    assign tail  = pipe[ROM_LAT-1];
    assign rdata = rom_q;

    always_comb begin
        rvalid = '0;
        if (!reset && tail.v) begin
            for (int i = 0; i < NREQ; i++) begin
                rvalid[i] = (tail.id == req_id_t'(i));
            end
        end
    end

    always_comb begin
        pipe_any = 1'b0;
        for (int k = 0; k < ROM_LAT; k++) begin
            pipe_any = pipe_any | pipe[k].v;
        end
    end

    assign busy = pipe_any & ~reset;

endmodule
